// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: ID-side instruction fields, hazard-unit selects,
// same-cycle bypass data, and the registered EXE-stage view fed back out.
interface id_ex_stage_if #(
    parameter int DW     = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    // Instruction fields presented by the decode stage
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rA;
    logic [4:0]        id_rB;
    logic [4:0]        id_rw;
    logic              id_we;
    logic              id_mem_read;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DW-1:0]     rf_A;
    logic [DW-1:0]     rf_B;

    // Forward selects and stall/flush requests from the hazard unit
    logic              A_ALU;
    logic              B_ALU;
    logic              A_MEM;
    logic              B_MEM;
    logic              bubble;
    logic              flush;

    // Same-cycle bypass sources
    logic [DW-1:0]     exe_result;
    logic [DW-1:0]     mem_data;

    // Registered EXE-stage view
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [DW-1:0]     ex_A;
    logic [DW-1:0]     ex_B;
    logic [4:0]        ex_rw;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_we_alu;
    logic              ex_we_mem;
    logic              hold_id;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Upstream side: decode stage, hazard unit and bypass network
    modport master (
        output id_valid, id_pc, id_rA, id_rB, id_rw, id_we, id_mem_read, id_ctrl,
        output rf_A, rf_B, A_ALU, B_ALU, A_MEM, B_MEM, bubble, flush,
        output exe_result, mem_data,
        input  ex_valid, ex_pc, ex_A, ex_B, ex_rw, ex_ctrl, ex_we_alu, ex_we_mem,
        input  hold_id, bubble_cnt, flush_cnt
    );

    // The pipeline register itself
    modport slave (
        input  id_valid, id_pc, id_rA, id_rB, id_rw, id_we, id_mem_read, id_ctrl,
        input  rf_A, rf_B, A_ALU, B_ALU, A_MEM, B_MEM, bubble, flush,
        input  exe_result, mem_data,
        output ex_valid, ex_pc, ex_A, ex_B, ex_rw, ex_ctrl, ex_we_alu, ex_we_mem,
        output hold_id, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding at the boundary, load-use bubbles,
// branch flushes, and saturating hazard-event counters.
module id_ex_stage #(
    parameter int DW     = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    id_ex_stage_if.slave   bus
);
    // Handshake: the ID instruction is accepted at a rising edge when id_valid=1
    // and hold_id=0. With hold_id=1 the decode stage must present the same
    // instruction again next cycle; flush kills it and always accepts.

    typedef enum logic [1:0] {
        UPD_IDLE  = 2'd0,
        UPD_LOAD  = 2'd1,
        UPD_STALL = 2'd2,
        UPD_FLUSH = 2'd3
    } upd_e;

    upd_e              upd;
    logic [DW-1:0]     a_next;
    logic [DW-1:0]     b_next;

    logic              ex_valid_q,    ex_valid_d;
    logic [31:0]       ex_pc_q,       ex_pc_d;
    logic [DW-1:0]     ex_a_q,        ex_a_d;
    logic [DW-1:0]     ex_b_q,        ex_b_d;
    logic [4:0]        ex_rw_q,       ex_rw_d;
    logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
    logic              ex_we_q,       ex_we_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic [CNT_W-1:0]  bubble_cnt_q,  bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,   flush_cnt_d;

    // The EXE result is the youngest producer, so it beats MEM/WB data.
    always_comb begin
        a_next = bus.rf_A;
        if (bus.A_ALU)      a_next = bus.exe_result;
        else if (bus.A_MEM) a_next = bus.mem_data;

        b_next = bus.rf_B;
        if (bus.B_ALU)      b_next = bus.exe_result;
        else if (bus.B_MEM) b_next = bus.mem_data;
    end

    always_comb begin
        upd = UPD_IDLE;
        if (bus.flush)                    upd = UPD_FLUSH;
        else if (bus.id_valid && bus.bubble) upd = UPD_STALL;
        else if (bus.id_valid)            upd = UPD_LOAD;
    end

    always_comb begin
        ex_valid_d    = 1'b0;
        ex_pc_d       = '0;
        ex_a_d        = '0;
        ex_b_d        = '0;
        ex_rw_d       = '0;
        ex_ctrl_d     = '0;
        ex_we_d       = 1'b0;
        ex_mem_read_d = 1'b0;
        bubble_cnt_d  = bubble_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        unique case (upd)
            UPD_LOAD: begin
                ex_valid_d    = 1'b1;
                ex_pc_d       = bus.id_pc;
                ex_a_d        = a_next;
                ex_b_d        = b_next;
                ex_rw_d       = bus.id_rw;
                ex_ctrl_d     = bus.id_ctrl;
                ex_we_d       = bus.id_we;
                ex_mem_read_d = bus.id_mem_read;
            end
            UPD_STALL: begin
                if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
            UPD_FLUSH: begin
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_rw_q       <= '0;
            ex_ctrl_q     <= '0;
            ex_we_q       <= 1'b0;
            ex_mem_read_q <= 1'b0;
            bubble_cnt_q  <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_rw_q       <= ex_rw_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_we_q       <= ex_we_d;
            ex_mem_read_q <= ex_mem_read_d;
            bubble_cnt_q  <= bubble_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign bus.hold_id    = bus.bubble & bus.id_valid & ~bus.flush & ~rst;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_pc      = ex_pc_q;
    assign bus.ex_A       = ex_a_q;
    assign bus.ex_B       = ex_b_q;
    assign bus.ex_rw      = ex_rw_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    // Decoded from flops only so the hazard unit never sees ID-side glitches.
    assign bus.ex_we_alu  = ex_we_q & ~ex_mem_read_q;
    assign bus.ex_we_mem  = ex_we_q & ex_mem_read_q;
    assign bus.bubble_cnt = bubble_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;

    // Source-register fields are consumed by the hazard unit, not here.
    logic unused_ok;
    assign unused_ok = ^{bus.id_rA, bus.id_rB};
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding priority, load-use,
// flush vs bubble, idle, counter saturation and reset during a stall.
module tb_id_ex_stage;
  localparam int DW     = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  id_ex_stage_if #(.DW(DW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DW(DW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.id_valid = 0; bus.id_pc = '0; bus.id_rA = '0; bus.id_rB = '0;
    bus.id_rw = '0; bus.id_we = 0; bus.id_mem_read = 0; bus.id_ctrl = '0;
    bus.rf_A = '0; bus.rf_B = '0; bus.A_ALU = 0; bus.B_ALU = 0;
    bus.A_MEM = 0; bus.B_MEM = 0; bus.bubble = 0; bus.flush = 0;
    bus.exe_result = '0; bus.mem_data = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    bus.id_valid = 1; bus.bubble = 1; bus.id_pc = 32'h40; bus.rf_A = 32'h99;
    bus.id_rw = 5'd7; bus.id_we = 1; bus.id_ctrl = 16'hFFFF;
    step();
    step();
    n_checks++; if (bus.hold_id !== 1'b0) $display("FAIL reset_hold_id: got %b want 0", bus.hold_id); else n_pass++;
    n_checks++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid); else n_pass++;
    n_checks++; if (bus.ex_pc !== 32'h0) $display("FAIL reset_ex_pc: got %h want 0", bus.ex_pc); else n_pass++;
    n_checks++; if (bus.ex_A !== 32'h0 || bus.ex_B !== 32'h0) $display("FAIL reset_ex_ab: got %h/%h want 0/0", bus.ex_A, bus.ex_B); else n_pass++;
    n_checks++; if (bus.ex_rw !== 5'd0 || bus.ex_ctrl !== 16'h0) $display("FAIL reset_rw_ctrl: got %h/%h want 0/0", bus.ex_rw, bus.ex_ctrl); else n_pass++;
    n_checks++; if (bus.ex_we_alu !== 1'b0 || bus.ex_we_mem !== 1'b0) $display("FAIL reset_we: got %b%b want 00", bus.ex_we_alu, bus.ex_we_mem); else n_pass++;
    n_checks++; if (bus.bubble_cnt !== 4'h0 || bus.flush_cnt !== 4'h0) $display("FAIL reset_cnt: got %h/%h want 0/0", bus.bubble_cnt, bus.flush_cnt); else n_pass++;
    rst = 0;
    drive_idle();
    step();
  endtask

  task automatic test_plain_load();
    drive_idle();
    bus.id_valid = 1; bus.id_pc = 32'h100; bus.rf_A = 32'h11; bus.rf_B = 32'h22;
    bus.id_rw = 5'd5; bus.id_we = 1; bus.id_ctrl = 16'h1234;
    #1;
    n_checks++; if (bus.hold_id !== 1'b0) $display("FAIL load_hold_id: got %b want 0", bus.hold_id); else n_pass++;
    step();
    n_checks++; if (bus.ex_A !== 32'h11 || bus.ex_B !== 32'h22) $display("FAIL load_ab: got %h/%h want 11/22", bus.ex_A, bus.ex_B); else n_pass++;
    n_checks++; if (bus.ex_rw !== 5'd5 || bus.ex_valid !== 1'b1) $display("FAIL load_rw_valid: got %0d/%b want 5/1", bus.ex_rw, bus.ex_valid); else n_pass++;
    n_checks++; if (bus.ex_we_alu !== 1'b1 || bus.ex_we_mem !== 1'b0) $display("FAIL load_we: got alu=%b mem=%b want 1/0", bus.ex_we_alu, bus.ex_we_mem); else n_pass++;
    n_checks++; if (bus.ex_pc !== 32'h100 || bus.ex_ctrl !== 16'h1234) $display("FAIL load_pc_ctrl: got %h/%h want 100/1234", bus.ex_pc, bus.ex_ctrl); else n_pass++;
  endtask

  task automatic test_forward();
    drive_idle();
    bus.id_valid = 1; bus.id_pc = 32'h104; bus.rf_A = 32'h1; bus.rf_B = 32'h2;
    bus.A_ALU = 1; bus.A_MEM = 1; bus.B_MEM = 1;
    bus.exe_result = 32'hAAAA; bus.mem_data = 32'hBBBB;
    step();
    n_checks++; if (bus.ex_A !== 32'hAAAA || bus.ex_B !== 32'hBBBB) $display("FAIL fwd_priority: got %h/%h want aaaa/bbbb", bus.ex_A, bus.ex_B); else n_pass++;
    bus.A_ALU = 0; bus.A_MEM = 0; bus.B_MEM = 1; bus.B_ALU = 1;
    bus.exe_result = 32'hC0DE; bus.mem_data = 32'hDEAD;
    step();
    n_checks++; if (bus.ex_A !== 32'h1 || bus.ex_B !== 32'hC0DE) $display("FAIL fwd_b_alu: got %h/%h want 1/c0de", bus.ex_A, bus.ex_B); else n_pass++;
    bus.B_ALU = 0; bus.B_MEM = 0; bus.A_MEM = 1;
    step();
    n_checks++; if (bus.ex_A !== 32'hDEAD || bus.ex_B !== 32'h2) $display("FAIL fwd_a_mem: got %h/%h want dead/2", bus.ex_A, bus.ex_B); else n_pass++;
  endtask

  task automatic test_load_use();
    drive_idle();
    // lw r3 enters EXE
    bus.id_valid = 1; bus.id_pc = 32'h200; bus.id_rw = 5'd3; bus.id_we = 1; bus.id_mem_read = 1;
    step();
    n_checks++; if (bus.ex_we_mem !== 1'b1 || bus.ex_we_alu !== 1'b0) $display("FAIL lu_load_we: got alu=%b mem=%b want 0/1", bus.ex_we_alu, bus.ex_we_mem); else n_pass++;
    // dependent add r4 <- r3 with a bubble request
    bus.id_pc = 32'h204; bus.id_rA = 5'd3; bus.id_rw = 5'd4; bus.id_mem_read = 0;
    bus.rf_A = 32'h0BAD; bus.bubble = 1;
    #1;
    n_checks++; if (bus.hold_id !== 1'b1) $display("FAIL lu_hold_id: got %b want 1", bus.hold_id); else n_pass++;
    step();
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_we_mem !== 1'b0 || bus.ex_rw !== 5'd0) $display("FAIL lu_nop: got v=%b wm=%b rw=%0d want 0/0/0", bus.ex_valid, bus.ex_we_mem, bus.ex_rw); else n_pass++;
    n_checks++; if (bus.bubble_cnt !== 4'd1) $display("FAIL lu_bubble_cnt: got %0d want 1", bus.bubble_cnt); else n_pass++;
    bus.bubble = 0; bus.A_MEM = 1; bus.mem_data = 32'h5555;
    #1;
    n_checks++; if (bus.hold_id !== 1'b0) $display("FAIL lu_reissue_hold: got %b want 0", bus.hold_id); else n_pass++;
    step();
    n_checks++; if (bus.ex_A !== 32'h5555 || bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h204) $display("FAIL lu_reissue: got A=%h v=%b pc=%h want 5555/1/204", bus.ex_A, bus.ex_valid, bus.ex_pc); else n_pass++;
  endtask

  task automatic test_flush_bubble();
    drive_idle();
    bus.id_valid = 1; bus.id_pc = 32'h300; bus.rf_A = 32'h77; bus.id_rw = 5'd9;
    bus.id_we = 1; bus.id_ctrl = 16'hBEEF; bus.bubble = 1; bus.flush = 1;
    #1;
    n_checks++; if (bus.hold_id !== 1'b0) $display("FAIL fb_hold_id: got %b want 0", bus.hold_id); else n_pass++;
    step();
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 16'h0 || bus.ex_rw !== 5'd0) $display("FAIL fb_nop: got v=%b ctrl=%h rw=%0d want 0/0/0", bus.ex_valid, bus.ex_ctrl, bus.ex_rw); else n_pass++;
    n_checks++; if (bus.ex_pc !== 32'h0 || bus.ex_A !== 32'h0 || bus.ex_we_alu !== 1'b0) $display("FAIL fb_clear: got pc=%h A=%h wa=%b want 0/0/0", bus.ex_pc, bus.ex_A, bus.ex_we_alu); else n_pass++;
    n_checks++; if (bus.flush_cnt !== 4'd1 || bus.bubble_cnt !== 4'd1) $display("FAIL fb_cnt: got f=%0d b=%0d want 1/1", bus.flush_cnt, bus.bubble_cnt); else n_pass++;
  endtask

  task automatic test_idle();
    drive_idle();
    bus.bubble = 1; bus.rf_A = 32'h1234;
    #1;
    n_checks++; if (bus.hold_id !== 1'b0) $display("FAIL idle_hold_id: got %b want 0", bus.hold_id); else n_pass++;
    step();
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_A !== 32'h0) $display("FAIL idle_nop: got v=%b A=%h want 0/0", bus.ex_valid, bus.ex_A); else n_pass++;
    n_checks++; if (bus.bubble_cnt !== 4'd1 || bus.flush_cnt !== 4'd1) $display("FAIL idle_cnt: got b=%0d f=%0d want 1/1", bus.bubble_cnt, bus.flush_cnt); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_bub;
    int bad;
    exp_bub = 4'd1;
    bad = 0;
    drive_idle();
    bus.id_valid = 1; bus.bubble = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_bub != 4'hF) exp_bub = exp_bub + 4'd1;
      n_checks++;
      if (bus.bubble_cnt !== exp_bub) begin
        $display("FAIL sat_step%0d: got %h want %h", i, bus.bubble_cnt, exp_bub);
      end else n_pass++;
    end
    n_checks++; if (bus.flush_cnt !== 4'd1) $display("FAIL sat_flush_cnt: got %0d want 1", bus.flush_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    drive_idle();
    bus.id_valid = 1; bus.bubble = 1; bus.id_rw = 5'd6; bus.id_we = 1;
    #1;
    n_checks++; if (bus.hold_id !== 1'b1) $display("FAIL rms_pre_hold: got %b want 1", bus.hold_id); else n_pass++;
    rst = 1;
    #1;
    n_checks++; if (bus.hold_id !== 1'b0) $display("FAIL rms_rst_hold: got %b want 0", bus.hold_id); else n_pass++;
    step();
    rst = 0;
    drive_idle();
    #1;
    n_checks++; if (bus.hold_id !== 1'b0 || bus.ex_valid !== 1'b0) $display("FAIL rms_after: got hold=%b v=%b want 0/0", bus.hold_id, bus.ex_valid); else n_pass++;
    n_checks++; if (bus.bubble_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) $display("FAIL rms_cnt: got b=%0d f=%0d want 0/0", bus.bubble_cnt, bus.flush_cnt); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1;
    drive_idle();
    test_reset();
    test_plain_load();
    test_forward();
    test_load_use();
    test_flush_bubble();
    test_idle();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
